rgb24max3_core: RTL and testbench

//  Digital behavioural model of the 3-channel, 24 mA-max RGB LED constant-current sink driver.

---
 rtl/rgb24max3_pkg.sv | 22 ++
 rtl/rgb_sink_channel.sv | 40 ++++
 rtl/rgb24max3_core.sv | 100 ++++++++++
 tb/tb_rgb24max3_core.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rgb24max3_pkg.sv
// Shared constants and helpers for the 3-channel RGB LED constant-current sink model.
package rgb24max3_pkg;

  localparam int unsigned STEP_FULL_MA = 4;
  localparam int unsigned STEP_HALF_MA = 2;
  localparam int unsigned CODE_W       = 6;
  localparam int unsigned MA_W         = 5;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [MA_W-1:0]   ma_t;

  // Each set code bit enables one current step, so any bit pattern is legal.
  function automatic logic [2:0] popcount6(input code_t code);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(CODE_W); i++) begin
      cnt = cnt + {2'b00, code[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rgb_sink_channel.sv
// One open-drain LED sink: registers the sink state and its reported current,
// and drives the pad low while sinking.
module rgb_sink_channel
  import rgb24max3_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  cond,
  input  logic  bias_ok,
  input  logic  pwm,
  input  code_t code,
  input  logic  half,
  output wire   pad,
  output ma_t   cur_ma
);

  logic sink_q, sink_d;
  ma_t  cur_q, cur_d;
  ma_t  step;

  always_comb begin
    sink_d = cond & bias_ok & pwm & (code != '0);
    step   = half ? MA_W'(STEP_HALF_MA) : MA_W'(STEP_FULL_MA);
    cur_d  = sink_d ? ma_t'(MA_W'(popcount6(code)) * step) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sink_q <= 1'b0;
      cur_q  <= '0;
    end else begin
      sink_q <= sink_d;
      cur_q  <= cur_d;
    end
  end

  assign pad    = sink_q ? 1'b0 : 1'bz;
  assign cur_ma = cur_q;

endmodule

// File: rtl/rgb24max3_core.sv
// Behavioural core of the 3-channel 24 mA RGB sink driver: enable qualification,
// bias start-up delay, and three PWM-gated sink channels.
module rgb24max3_core
  import rgb24max3_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cbit_rgb_en,
  input  logic        cbit_rgb_half_cur,
  input  logic        i200uref,
  input  logic        poc,
  input  logic        rgbled_en,
  input  logic        vccio,
  input  logic [2:0]  rgb_pwm,
  input  code_t       cbit_rgb0,
  input  code_t       cbit_rgb1,
  input  code_t       cbit_rgb2,
  output wire         rgb0,
  output wire         rgb1,
  output wire         rgb2,
  output logic [14:0] cur_ma,
  output logic        bias_ok
);

  localparam int unsigned CntW = (STARTUP_CYCLES == 0) ? 1 : $clog2(STARTUP_CYCLES + 1);

  logic            cond;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bias_q, bias_d;
  ma_t             cur0, cur1, cur2;

  assign cond = cbit_rgb_en & rgbled_en & i200uref & vccio & ~poc;

  // Counter saturates at STARTUP_CYCLES so bias_ok stays high while cond holds.
  always_comb begin
    cnt_d  = cnt_q;
    bias_d = bias_q;
    if (!cond) begin
      cnt_d  = '0;
      bias_d = 1'b0;
    end else begin
      if (32'(cnt_q) < STARTUP_CYCLES) begin
        cnt_d = cnt_q + 1'b1;
      end
      bias_d = (32'(cnt_q) + 32'd1 >= STARTUP_CYCLES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      bias_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bias_q <= bias_d;
    end
  end

  rgb_sink_channel u_ch0 (
    .clk     (clk),
    .rst     (rst),
    .cond    (cond),
    .bias_ok (bias_q),
    .pwm     (rgb_pwm[0]),
    .code    (cbit_rgb0),
    .half    (cbit_rgb_half_cur),
    .pad     (rgb0),
    .cur_ma  (cur0)
  );

  rgb_sink_channel u_ch1 (
    .clk     (clk),
    .rst     (rst),
    .cond    (cond),
    .bias_ok (bias_q),
    .pwm     (rgb_pwm[1]),
    .code    (cbit_rgb1),
    .half    (cbit_rgb_half_cur),
    .pad     (rgb1),
    .cur_ma  (cur1)
  );

  rgb_sink_channel u_ch2 (
    .clk     (clk),
    .rst     (rst),
    .cond    (cond),
    .bias_ok (bias_q),
    .pwm     (rgb_pwm[2]),
    .code    (cbit_rgb2),
    .half    (cbit_rgb_half_cur),
    .pad     (rgb2),
    .cur_ma  (cur2)
  );

  assign cur_ma  = {cur2, cur1, cur0};
  assign bias_ok = bias_q;

endmodule

// File: tb/tb_rgb24max3_core.sv
// Scoreboard bench for rgb24max3_core: a per-edge reference model pushes expected
// outputs, a monitor compares them one time unit after each rising edge.
module tb_rgb24max3_core;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cbit_rgb_en, cbit_rgb_half_cur, i200uref, poc, rgbled_en, vccio;
  logic [2:0]  rgb_pwm;
  logic [5:0]  code [3];
  wire         rgb0, rgb1, rgb2;
  logic [14:0] cur_ma;
  logic        bias_ok;

  // Pads are open drain; a pull-up turns "not sinking" into a readable 1.
  pullup (rgb0);
  pullup (rgb1);
  pullup (rgb2);

  rgb24max3_core #(.STARTUP_CYCLES(S)) dut (
    .clk               (clk),
    .rst               (rst),
    .cbit_rgb_en       (cbit_rgb_en),
    .cbit_rgb_half_cur (cbit_rgb_half_cur),
    .i200uref          (i200uref),
    .poc               (poc),
    .rgbled_en         (rgbled_en),
    .vccio             (vccio),
    .rgb_pwm           (rgb_pwm),
    .cbit_rgb0         (code[0]),
    .cbit_rgb1         (code[1]),
    .cbit_rgb2         (code[2]),
    .rgb0              (rgb0),
    .rgb1              (rgb1),
    .rgb2              (rgb2),
    .cur_ma            (cur_ma),
    .bias_ok           (bias_ok)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  pads;
    logic [14:0] cur;
    logic        bias;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: consecutive qualified edges and current sinking lamps.
  int   run_m  = 0;
  bit   bias_m = 0;
  bit [2:0] on_m = '0;
  int   ma_m [3] = '{0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int n = 0; n < 3; n++) begin
      e.pads[n] = on_m[n] ? 1'b0 : 1'b1;
      e.cur[n*5 +: 5] = 5'(ma_m[n]);
    end
    e.bias = bias_m;
    return e;
  endfunction

  // One rising edge: advance the model from pre-edge inputs and queue the result.
  task automatic tick();
    bit cond;
    @(posedge clk);
    cond = cbit_rgb_en && rgbled_en && i200uref && vccio && !poc;
    if (rst || !cond) begin
      run_m  = 0;
      bias_m = 0;
      on_m   = '0;
      ma_m   = '{0, 0, 0};
    end else begin
      for (int n = 0; n < 3; n++) begin
        on_m[n] = bias_m && rgb_pwm[n] && (code[n] != 0);
        ma_m[n] = on_m[n] ? $countones(code[n]) * (cbit_rgb_half_cur ? 2 : 4) : 0;
      end
      run_m  = (run_m < S) ? run_m + 1 : S;
      bias_m = (run_m >= S);
    end
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("pads", {29'd0, rgb2, rgb1, rgb0}, {29'd0, e.pads});
      check("cur_ma", {17'd0, cur_ma}, {17'd0, e.cur});
      check("bias_ok", {31'd0, bias_ok}, {31'd0, e.bias});
    end
  end

  task automatic all_on();
    cbit_rgb_en = 1; rgbled_en = 1; i200uref = 1; vccio = 1; poc = 0;
  endtask

  initial begin
    rst = 1;
    all_on();
    cbit_rgb_half_cur = 0;
    rgb_pwm = 3'b111;
    code = '{6'd3, 6'd3, 6'd3};
    #1;
    check("reset_pads", {29'd0, rgb2, rgb1, rgb0}, 32'h7);
    check("reset_cur", {17'd0, cur_ma}, 32'h0);
    check("reset_bias", {31'd0, bias_ok}, 32'h0);
    tick(); tick();
    rst = 0;

    // Start-up: bias after edge 16, sinking 8 mA per channel after edge 17.
    for (int i = 0; i < 20; i++) tick();

    // Half mode, full code, pwm toggling every 4 clocks.
    cbit_rgb_half_cur = 1;
    code = '{6'h3f, 6'h3f, 6'h3f};
    for (int i = 0; i < 24; i++) begin
      rgb_pwm = ((i / 4) % 2 == 0) ? 3'b111 : 3'b000;
      tick();
    end

    // Zero code on ch1 keeps it off while the others sink.
    cbit_rgb_half_cur = 0;
    rgb_pwm = 3'b111;
    code = '{6'b101010, 6'd0, 6'b000111};
    for (int i = 0; i < 6; i++) tick();

    // One-clock drop of the reference, then a poc pulse; each restarts the delay.
    i200uref = 0; tick(); i200uref = 1;
    for (int i = 0; i < 20; i++) tick();
    poc = 1; tick(); poc = 0;
    for (int i = 0; i < 20; i++) tick();

    // vccio low or block disabled throughout: never biases.
    vccio = 0;
    for (int i = 0; i < 20; i++) begin
      rgb_pwm = 3'($urandom);
      tick();
    end
    vccio = 1; cbit_rgb_en = 0;
    for (int i = 0; i < 20; i++) tick();
    cbit_rgb_en = 1;

    // Random traffic with occasional enable drops.
    for (int i = 0; i < 400; i++) begin
      cbit_rgb_en       = ($urandom_range(0, 63) != 0);
      rgbled_en         = ($urandom_range(0, 63) != 0);
      i200uref          = ($urandom_range(0, 63) != 0);
      vccio             = ($urandom_range(0, 63) != 0);
      poc               = ($urandom_range(0, 63) == 0);
      cbit_rgb_half_cur = 1'($urandom);
      rgb_pwm           = 3'($urandom);
      for (int n = 0; n < 3; n++) code[n] = 6'($urandom);
      tick();
    end

    // Mid-run asynchronous reset while all channels sink.
    all_on();
    rgb_pwm = 3'b111;
    code = '{6'd1, 6'd2, 6'd4};
    for (int i = 0; i < S + 3; i++) tick();
    check("pre_reset_pads", {29'd0, rgb2, rgb1, rgb0}, 32'h0);
    rst = 1;
    #1;
    check("async_reset_pads", {29'd0, rgb2, rgb1, rgb0}, 32'h7);
    check("async_reset_cur", {17'd0, cur_ma}, 32'h0);
    check("async_reset_bias", {31'd0, bias_ok}, 32'h0);
    tick();
    rst = 0;
    tick();
    #2;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
